// File: rtl/conv2d_engine.sv
// Parametrised signed 2D convolution engine: walks KxK windows over an IMG_H x IMG_W image in RAM,
// multiply-accumulates against a loadable kernel and streams post-processed results row-major.
module conv2d_engine #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int DW     = 8,
    parameter int OW     = 16,
    parameter int STRIDE = 1,
    parameter int SHIFT  = 0,
    parameter int AW     = $clog2(IMG_W * IMG_H)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    sat_en,
    input  logic                    relu_en,
    input  logic                    k_wr,
    input  logic [$clog2(K*K)-1:0]  k_idx,
    input  logic signed [DW-1:0]    k_data,
    output logic [AW-1:0]           ram_addr,
    input  logic signed [DW-1:0]    ram_dout,
    output logic signed [OW-1:0]    dout,
    output logic                    out_st,
    output logic                    busy,
    output logic                    done
);

    localparam int NT    = K * K;
    localparam int KI    = $clog2(NT);
    localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
    localparam int OUT_H = (IMG_H - K) / STRIDE + 1;
    localparam int ACCW  = 2 * DW + $clog2(NT);
    localparam int EW    = (ACCW > OW) ? ACCW : OW;
    localparam int KW    = $clog2(K + 1);
    localparam int XW    = $clog2(OUT_W + 1);
    localparam int YW    = $clog2(OUT_H + 1);

    localparam logic [KI-1:0] TAP_LAST = KI'(NT - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(K - 1);
    localparam logic [XW-1:0] OX_LAST  = XW'(OUT_W - 1);
    localparam logic [YW-1:0] OY_LAST  = YW'(OUT_H - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAIN = 3'd2,
        S_EMIT  = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic signed [DW-1:0]    w_r [NT];
    logic [XW-1:0]           ox_r;
    logic [YW-1:0]           oy_r;
    logic [KW-1:0]           kx_r;
    logic [KW-1:0]           ky_r;
    logic [KI-1:0]           tap_r;
    logic                    mac_vld_r;
    logic [KI-1:0]           mac_tap_r;
    logic signed [ACCW-1:0]  acc_r;
    logic signed [2*DW-1:0]  prod_s;
    logic                    last_win_s;

    function automatic logic [AW-1:0] tap_addr(input logic [XW-1:0] ox, input logic [YW-1:0] oy,
                                               input logic [KW-1:0] ky, input logic [KW-1:0] kx);
        int a;
        a = (int'(oy) * STRIDE + int'(ky)) * IMG_W + int'(ox) * STRIDE + int'(kx);
        return AW'(a);
    endfunction

    // Shift, then clamp or wrap into OW bits, then optional ReLU.
    function automatic logic signed [OW-1:0] post_proc(input logic signed [ACCW-1:0] acc,
                                                       input logic sat, input logic relu);
        logic signed [EW-1:0] s;
        logic signed [OW-1:0] r;
        logic                 fits;
        s    = EW'(acc >>> SHIFT);
        fits = (s[EW-1:OW-1] == {(EW-OW+1){s[OW-1]}});
        if (!sat || fits) begin
            r = s[OW-1:0];
        end else if (s[EW-1]) begin
            r = {1'b1, {(OW-1){1'b0}}};
        end else begin
            r = {1'b0, {(OW-1){1'b1}}};
        end
        r = (relu && r[OW-1]) ? {OW{1'b0}} : r;
        return r;
    endfunction

    // Product of the RAM word returned this cycle with the weight of the tap that addressed it.
    always_comb begin
        prod_s     = {{DW{ram_dout[DW-1]}}, ram_dout} * {{DW{w_r[mac_tap_r][DW-1]}}, w_r[mac_tap_r]};
        last_win_s = (ox_r == OX_LAST) && (oy_r == OY_LAST);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:  state_s = start ? S_FETCH : S_IDLE;
            S_FETCH: state_s = (tap_r == TAP_LAST) ? S_DRAIN : S_FETCH;
            S_DRAIN: state_s = S_EMIT;
            S_EMIT:  state_s = last_win_s ? S_FIN : S_FETCH;
            S_FIN:   state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Datapath: kernel store, window/tap counters, address generation, MAC and output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NT; i++) begin
                w_r[i] <= {DW{1'b0}};
            end
            ox_r      <= {XW{1'b0}};
            oy_r      <= {YW{1'b0}};
            kx_r      <= {KW{1'b0}};
            ky_r      <= {KW{1'b0}};
            tap_r     <= {KI{1'b0}};
            mac_vld_r <= 1'b0;
            mac_tap_r <= {KI{1'b0}};
            acc_r     <= {ACCW{1'b0}};
            ram_addr  <= {AW{1'b0}};
            dout      <= {OW{1'b0}};
            out_st    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            out_st    <= 1'b0;
            done      <= 1'b0;
            mac_vld_r <= 1'b0;
            // Tap 0 restarts the sum so nothing leaks from the previous window.
            if (mac_vld_r) begin
                acc_r <= ((mac_tap_r == {KI{1'b0}}) ? {ACCW{1'b0}} : acc_r) + ACCW'(prod_s);
            end else begin
                acc_r <= acc_r;
            end
            case (state_r)
                S_IDLE: begin
                    if (k_wr && (k_idx <= TAP_LAST)) begin
                        w_r[k_idx] <= k_data;
                    end
                    if (start) begin
                        busy     <= 1'b1;
                        ox_r     <= {XW{1'b0}};
                        oy_r     <= {YW{1'b0}};
                        kx_r     <= {KW{1'b0}};
                        ky_r     <= {KW{1'b0}};
                        tap_r    <= {KI{1'b0}};
                        ram_addr <= {AW{1'b0}};
                    end
                end
                S_FETCH: begin
                    mac_vld_r <= 1'b1;
                    mac_tap_r <= tap_r;
                    if (tap_r != TAP_LAST) begin
                        tap_r <= tap_r + KI'(1);
                        if (kx_r == K_LAST) begin
                            kx_r     <= {KW{1'b0}};
                            ky_r     <= ky_r + KW'(1);
                            ram_addr <= tap_addr(ox_r, oy_r, ky_r + KW'(1), {KW{1'b0}});
                        end else begin
                            kx_r     <= kx_r + KW'(1);
                            ram_addr <= tap_addr(ox_r, oy_r, ky_r, kx_r + KW'(1));
                        end
                    end else begin
                        tap_r <= {KI{1'b0}};
                        kx_r  <= {KW{1'b0}};
                        ky_r  <= {KW{1'b0}};
                    end
                end
                S_DRAIN: begin
                    busy <= 1'b1;
                end
                S_EMIT: begin
                    dout   <= post_proc(acc_r, sat_en, relu_en);
                    out_st <= 1'b1;
                    // Advance ox first, then oy, and pre-load tap 0 of the next window.
                    if (!last_win_s) begin
                        if (ox_r == OX_LAST) begin
                            ox_r     <= {XW{1'b0}};
                            oy_r     <= oy_r + YW'(1);
                            ram_addr <= tap_addr({XW{1'b0}}, oy_r + YW'(1), {KW{1'b0}}, {KW{1'b0}});
                        end else begin
                            ox_r     <= ox_r + XW'(1);
                            ram_addr <= tap_addr(ox_r + XW'(1), oy_r, {KW{1'b0}}, {KW{1'b0}});
                        end
                    end
                end
                S_FIN: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv2d_engine.sv
// Scoreboard bench for conv2d_engine: three instances (defaults, STRIDE=2, SHIFT=2) share one image
// model; expected results are computed from the image and kernel and queued at each start.
module tb_conv2d_engine;

    localparam int NI = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              sat_en;
    logic              relu_en;
    logic              k_wr;
    logic [3:0]        k_idx;
    logic signed [7:0] k_data;
    logic [NI-1:0]     start;
    logic [5:0]        addr_a [NI];
    logic signed [7:0] rq_a   [NI];
    logic signed [15:0] dout_a [NI];
    logic [NI-1:0]     out_st_a;
    logic [NI-1:0]     busy_a;
    logic [NI-1:0]     done_a;

    logic signed [7:0] img [64];
    int                wt  [9];
    int                q   [$];
    int                n_tests = 0;
    int                n_fail  = 0;

    always #5 clk = ~clk;

    conv2d_engine u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .sat_en(sat_en), .relu_en(relu_en),
        .k_wr(k_wr), .k_idx(k_idx), .k_data(k_data), .ram_addr(addr_a[0]), .ram_dout(rq_a[0]),
        .dout(dout_a[0]), .out_st(out_st_a[0]), .busy(busy_a[0]), .done(done_a[0])
    );

    conv2d_engine #(.STRIDE(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .sat_en(sat_en), .relu_en(relu_en),
        .k_wr(k_wr), .k_idx(k_idx), .k_data(k_data), .ram_addr(addr_a[1]), .ram_dout(rq_a[1]),
        .dout(dout_a[1]), .out_st(out_st_a[1]), .busy(busy_a[1]), .done(done_a[1])
    );

    conv2d_engine #(.SHIFT(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start[2]), .sat_en(sat_en), .relu_en(relu_en),
        .k_wr(k_wr), .k_idx(k_idx), .k_data(k_data), .ram_addr(addr_a[2]), .ram_dout(rq_a[2]),
        .dout(dout_a[2]), .out_st(out_st_a[2]), .busy(busy_a[2]), .done(done_a[2])
    );

    // Synchronous-read image RAM, one read port per instance.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            rq_a[i] <= img[addr_a[i]];
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Every result pulse is compared with the oldest queued expectation.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (out_st_a[i]) begin
                if (q.size() == 0) begin
                    check_eq("unexpected out_st", 1, 0);
                end else begin
                    check_eq("dout", int'(dout_a[i]), q.pop_front());
                end
            end
        end
    end

    function automatic int post_m(input longint a, input int sh, input bit sat, input bit relu);
        longint s;
        int     r;
        s = a >>> sh;
        if (sat) begin
            if (s > 64'sd32767)       r = 32767;
            else if (s < -64'sd32768) r = -32768;
            else                      r = int'(s);
        end else begin
            r = int'(s) & 32'h0000FFFF;
            if (r >= 32768) r = r - 65536;
        end
        if (relu && r < 0) r = 0;
        return r;
    endfunction

    task automatic push_expected(input int stride, input int sh, input bit sat, input bit relu);
        int     nout;
        longint acc;
        nout = (8 - 3) / stride + 1;
        for (int oy = 0; oy < nout; oy++) begin
            for (int ox = 0; ox < nout; ox++) begin
                acc = 0;
                for (int ky = 0; ky < 3; ky++) begin
                    for (int kx = 0; kx < 3; kx++) begin
                        acc += longint'(img[(oy * stride + ky) * 8 + ox * stride + kx]) * longint'(wt[ky * 3 + kx]);
                    end
                end
                q.push_back(post_m(acc, sh, sat, relu));
            end
        end
    endtask

    task automatic load_kernel();
        for (int t = 0; t < 9; t++) begin
            @(negedge clk);
            k_wr   = 1'b1;
            k_idx  = 4'(t);
            k_data = 8'(wt[t]);
        end
        @(negedge clk);
        k_wr = 1'b0;
    endtask

    task automatic set_img(input int mode, input int val);
        for (int i = 0; i < 64; i++) begin
            img[i] = (mode == 1) ? 8'(i) : 8'(val);
        end
    endtask

    task automatic set_wt(input int mode, input int val);
        for (int t = 0; t < 9; t++) begin
            wt[t] = (mode == 1) ? ((t == 4) ? 1 : 0) : val;
        end
    endtask

    // One full-image run on instance id; poke drives start and k_wr while the engine is busy.
    task automatic run(input int id, input int stride, input int sh, input string tag,
                       input bit chk_lat, input bit poke);
        int lat;
        int cyc;
        int last_st;
        bit got_done;
        push_expected(stride, sh, sat_en, relu_en);
        @(negedge clk);
        start[id] = 1'b1;
        @(negedge clk);
        start[id] = 1'b0;
        check_eq({tag, " busy"}, int'(busy_a[id]), 1);
        cyc = 0; last_st = -100; lat = -1; got_done = 1'b0;
        while (!got_done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (out_st_a[id]) begin
                if (lat < 0) lat = cyc;
                last_st = cyc;
            end
            if (done_a[id]) begin
                got_done = 1'b1;
                check_eq({tag, " done gap"}, cyc - last_st, 1);
                check_eq({tag, " busy at done"}, int'(busy_a[id]), 0);
            end
            if (poke && cyc == 20) begin
                start[id] = 1'b1;
                k_wr      = 1'b1;
                k_idx     = 4'd4;
                k_data    = 8'sd5;
            end else if (poke && cyc == 21) begin
                start[id] = 1'b0;
                k_wr      = 1'b0;
            end
        end
        check_eq({tag, " done seen"}, int'(got_done), 1);
        if (chk_lat) check_eq({tag, " first latency"}, lat, 11);
        check_eq({tag, " leftover"}, q.size(), 0);
        q.delete();
    endtask

    initial begin
        int  seen;
        int  cyc;
        bit  stray;
        rst = 1'b1; start = '0; k_wr = 1'b0; k_idx = 4'd0; k_data = 8'sd0;
        sat_en = 1'b0; relu_en = 1'b0;
        set_img(0, 0);
        set_wt(0, 0);
        repeat (3) @(negedge clk);
        check_eq("reset dout", int'(dout_a[0]), 0);
        check_eq("reset out_st", int'(out_st_a[0]), 0);
        check_eq("reset busy", int'(busy_a[0]), 0);
        check_eq("reset done", int'(done_a[0]), 0);
        check_eq("reset ram_addr", int'(addr_a[0]), 0);
        rst = 1'b0;

        // Identity over a ramp; the busy-time start/k_wr must not change this run or the next.
        set_img(1, 0); set_wt(1, 0); load_kernel();
        run(0, 1, 0, "t1_identity", 1'b1, 1'b1);
        run(0, 1, 0, "t1_hold", 1'b1, 1'b0);

        set_img(0, 127); set_wt(0, 1); load_kernel();
        run(0, 1, 0, "t2_ones", 1'b0, 1'b0);

        set_img(0, -128); set_wt(0, -128); load_kernel();
        sat_en = 1'b1;
        run(0, 1, 0, "t3_sat", 1'b0, 1'b0);
        sat_en = 1'b0;
        run(0, 1, 0, "t3_wrap", 1'b0, 1'b0);

        set_img(0, 1); set_wt(0, -1); load_kernel();
        run(0, 1, 0, "t4_neg", 1'b0, 1'b0);
        relu_en = 1'b1;
        run(0, 1, 0, "t4_relu", 1'b0, 1'b0);
        relu_en = 1'b0;

        set_img(1, 0); set_wt(1, 0); load_kernel();
        run(1, 2, 0, "t5_stride2", 1'b0, 1'b0);
        set_img(0, 127); set_wt(0, 1); load_kernel();
        run(2, 1, 2, "t5_shift2", 1'b0, 1'b0);

        // Reset partway through window 5.
        set_img(1, 0); set_wt(1, 0); load_kernel();
        push_expected(1, 0, 1'b0, 1'b0);
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        seen = 0; cyc = 0;
        while (seen < 5 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (out_st_a[0]) seen++;
        end
        check_eq("t6 five results", seen, 5);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        check_eq("t6 dout", int'(dout_a[0]), 0);
        check_eq("t6 out_st", int'(out_st_a[0]), 0);
        check_eq("t6 busy", int'(busy_a[0]), 0);
        check_eq("t6 done", int'(done_a[0]), 0);
        check_eq("t6 ram_addr", int'(addr_a[0]), 0);
        stray = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (done_a[0] || out_st_a[0] || busy_a[0]) stray = 1'b1;
        end
        check_eq("t6 quiet after reset", int'(stray), 0);

        // Reset cleared the kernel, so a fresh run yields zeros.
        set_wt(0, 0);
        run(0, 1, 0, "t6_cleared", 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
